// File: rtl/data_memory_pkg.sv
// Shared types and constants for the word-organised data memory.
package data_memory_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int unsigned MIN_READ_LATENCY = 1;
    localparam int unsigned MAX_READ_LATENCY = 4;

    // Number of byte-offset bits inside one word (0 for byte-wide words).
    function automatic int unsigned byte_offset_width(input int unsigned word_size);
        int unsigned bytes;
        bytes = word_size / 8;
        return (bytes <= 1) ? 0 : $clog2(bytes);
    endfunction

endpackage

// File: rtl/data_memory_response_pipe.sv
// Fixed-depth response pipeline; every accepted request emerges READ_LATENCY edges later.
module data_memory_response_pipe
    import data_memory_pkg::*;
#(
    parameter int unsigned WORD_SIZE    = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 in_write,
    input  logic [WORD_SIZE-1:0] in_data,
    input  logic                 in_err_invalid_address,
    input  logic                 in_err_misaligned,
    output logic                 out_valid,
    output logic                 out_write,
    output logic [WORD_SIZE-1:0] out_data,
    output logic                 out_err_invalid_address,
    output logic                 out_err_misaligned
);

    logic [READ_LATENCY-1:0]                valid_q;
    logic [READ_LATENCY-1:0]                write_q;
    logic [READ_LATENCY-1:0][WORD_SIZE-1:0] data_q;
    logic [READ_LATENCY-1:0]                inv_q;
    logic [READ_LATENCY-1:0]                mis_q;

    // Shift register; reset drops every in-flight response.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            write_q <= '0;
            data_q  <= '0;
            inv_q   <= '0;
            mis_q   <= '0;
        end else begin
            valid_q[0] <= in_valid;
            write_q[0] <= in_write;
            data_q[0]  <= in_data;
            inv_q[0]   <= in_err_invalid_address;
            mis_q[0]   <= in_err_misaligned;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                write_q[i] <= write_q[i-1];
                data_q[i]  <= data_q[i-1];
                inv_q[i]   <= inv_q[i-1];
                mis_q[i]   <= mis_q[i-1];
            end
        end
    end

    assign out_valid               = valid_q[READ_LATENCY-1];
    assign out_write               = write_q[READ_LATENCY-1];
    assign out_data                = data_q[READ_LATENCY-1];
    assign out_err_invalid_address = inv_q[READ_LATENCY-1];
    assign out_err_misaligned      = mis_q[READ_LATENCY-1];

endmodule

// File: rtl/data_memory.sv
// Word-organised data memory with valid/ready requests, byte-lane stores,
// self-clear after reset and in-order fixed-latency responses.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int unsigned MEMORY_SIZE   = 1024,
    parameter int unsigned WORD_SIZE     = 32,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned READ_LATENCY  = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDRESS_WIDTH-1:0] req_address,
    input  logic [WORD_SIZE/8-1:0]   req_byte_enable,
    input  logic [WORD_SIZE-1:0]     req_data,
    output logic                     resp_valid,
    output logic                     resp_write,
    output logic [WORD_SIZE-1:0]     resp_data,
    output logic                     err_invalid_address,
    output logic                     err_misaligned
);

    localparam int unsigned BYTES    = WORD_SIZE / 8;
    localparam int unsigned OFFSET_W = byte_offset_width(WORD_SIZE);
    localparam int unsigned INDEX_W  = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;

    // Reject illegal pipeline depths at elaboration.
    if ((READ_LATENCY < MIN_READ_LATENCY) || (READ_LATENCY > MAX_READ_LATENCY)) begin : g_bad_latency
        $error("data_memory: READ_LATENCY out of range");
    end

    logic [WORD_SIZE-1:0] mem [MEMORY_SIZE];

    state_t               state;
    state_t               state_next;
    logic [INDEX_W-1:0]   clear_index;
    logic [INDEX_W-1:0]   clear_index_next;

    logic [ADDRESS_WIDTH-1:0] word_index;
    logic [INDEX_W-1:0]       mem_index;
    logic                     invalid;
    logic                     misaligned;
    logic                     accept;
    logic                     access_ok;
    logic                     write_ok;
    logic [WORD_SIZE-1:0]     read_word;
    logic [WORD_SIZE-1:0]     stage_data;

    // Address decode at full address width so out-of-range words never alias.
    assign word_index = req_address >> OFFSET_W;
    assign invalid    = word_index >= ADDRESS_WIDTH'(MEMORY_SIZE);
    assign mem_index  = word_index[INDEX_W-1:0];

    if (OFFSET_W > 0) begin : g_offset
        assign misaligned = |req_address[OFFSET_W-1:0];
    end else begin : g_no_offset
        assign misaligned = 1'b0;
    end

    assign req_ready = (state == READY) && !reset;
    assign accept    = req_valid && req_ready;
    assign access_ok = accept && !invalid && !misaligned;
    assign write_ok  = access_ok && req_write;
    assign read_word = mem[mem_index];
    assign stage_data = (access_ok && !req_write) ? read_word : '0;

    // State register and clear counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= CLEAR;
            clear_index <= '0;
        end else begin
            state       <= state_next;
            clear_index <= clear_index_next;
        end
    end

    // Clear sweeps every word once, then hands over to normal operation.
    always_comb begin
        state_next       = state;
        clear_index_next = clear_index;
        case (state)
            CLEAR: begin
                clear_index_next = clear_index + INDEX_W'(1);
                if (clear_index == INDEX_W'(MEMORY_SIZE - 1)) begin
                    state_next       = READY;
                    clear_index_next = '0;
                end
            end
            READY: begin
                state_next = READY;
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    // Array write port: clear sweep or lane-masked store.
    always_ff @(posedge clock) begin
        if (!reset && (state == CLEAR)) begin
            mem[clear_index] <= '0;
        end else if (write_ok) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (req_byte_enable[b]) begin
                    mem[mem_index][8*b +: 8] <= req_data[8*b +: 8];
                end
            end
        end
    end

    data_memory_response_pipe #(
        .WORD_SIZE    (WORD_SIZE),
        .READ_LATENCY (READ_LATENCY)
    ) u_response_pipe (
        .clock                   (clock),
        .reset                   (reset),
        .in_valid                (accept),
        .in_write                (accept && req_write),
        .in_data                 (stage_data),
        .in_err_invalid_address  (accept && invalid),
        .in_err_misaligned       (accept && misaligned),
        .out_valid               (resp_valid),
        .out_write               (resp_write),
        .out_data                (resp_data),
        .out_err_invalid_address (err_invalid_address),
        .out_err_misaligned      (err_misaligned)
    );

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: behavioural memory/queue model plus directed literal checks.
module tb_data_memory;

    localparam int unsigned MEM = 16;
    localparam int unsigned WS  = 32;
    localparam int unsigned AW  = 32;
    localparam int unsigned RL  = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_address = '0;
    logic [3:0]    req_byte_enable = '0;
    logic [WS-1:0] req_data = '0;
    logic          resp_valid;
    logic          resp_write;
    logic [WS-1:0] resp_data;
    logic          err_invalid_address;
    logic          err_misaligned;

    data_memory #(
        .MEMORY_SIZE   (MEM),
        .WORD_SIZE     (WS),
        .ADDRESS_WIDTH (AW),
        .READ_LATENCY  (RL)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_write           (req_write),
        .req_address         (req_address),
        .req_byte_enable     (req_byte_enable),
        .req_data            (req_data),
        .resp_valid          (resp_valid),
        .resp_write          (resp_write),
        .resp_data           (resp_data),
        .err_invalid_address (err_invalid_address),
        .err_misaligned      (err_misaligned)
    );

    always #5 clock = ~clock;

    typedef struct {
        int unsigned due;
        logic        write;
        logic [31:0] data;
        logic        inv;
        logic        mis;
    } resp_t;

    resp_t       exp_q[$];
    logic [31:0] model_mem [MEM];
    int unsigned clr_left = 0;
    int unsigned cycle = 0;
    bit          started = 0;

    int          errors = 0;
    int          checks = 0;
    int unsigned resp_count = 0;
    logic [31:0] last_data = '0;
    logic        last_inv = 1'b0;
    logic        last_mis = 1'b0;
    logic        last_write = 1'b0;

    // Model: memory contents, clear time and the expected response stream.
    initial forever begin
        @(posedge clock);
        cycle++;
        if (reset) begin
            started  = 1;
            clr_left = MEM;
            exp_q.delete();
            for (int i = 0; i < int'(MEM); i++) model_mem[i] = '0;
        end else if (started) begin
            if (clr_left != 0) begin
                clr_left--;
            end else if (req_valid) begin
                resp_t       r;
                logic [31:0] widx;
                widx    = req_address / 4;
                r.due   = cycle + RL - 1;
                r.write = req_write;
                r.mis   = (req_address % 4) != 0;
                r.inv   = widx >= MEM;
                r.data  = '0;
                if (!r.mis && !r.inv) begin
                    if (!req_write) begin
                        r.data = model_mem[widx];
                    end else begin
                        for (int b = 0; b < 4; b++)
                            if (req_byte_enable[b]) model_mem[widx][8*b +: 8] = req_data[8*b +: 8];
                    end
                end
                exp_q.push_back(r);
            end
        end
    end

    // Every-cycle compare of DUT outputs against the model.
    initial forever begin
        logic        e_ready, e_valid, e_write, e_inv, e_mis;
        logic [31:0] e_data;
        @(negedge clock);
        if (started) begin
            e_ready = (clr_left == 0) && !reset;
            e_valid = 0; e_write = 0; e_data = '0; e_inv = 0; e_mis = 0;
            if (exp_q.size() != 0 && exp_q[0].due == cycle) begin
                e_valid = 1;
                e_write = exp_q[0].write;
                e_data  = exp_q[0].data;
                e_inv   = exp_q[0].inv;
                e_mis   = exp_q[0].mis;
                void'(exp_q.pop_front());
            end
            checks++;
            if (req_ready !== e_ready || resp_valid !== e_valid || resp_write !== e_write ||
                resp_data !== e_data || err_invalid_address !== e_inv || err_misaligned !== e_mis) begin
                errors++;
                $display("FAIL cycle %0d outputs: got rdy=%b v=%b w=%b d=%h inv=%b mis=%b, expected rdy=%b v=%b w=%b d=%h inv=%b mis=%b",
                         cycle, req_ready, resp_valid, resp_write, resp_data, err_invalid_address, err_misaligned,
                         e_ready, e_valid, e_write, e_data, e_inv, e_mis);
            end
            if (resp_valid === 1'b1) begin
                resp_count++;
                last_data  = resp_data;
                last_inv   = err_invalid_address;
                last_mis   = err_misaligned;
                last_write = resp_write;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
        @(negedge clock); #1;
        req_valid       = 1'b1;
        req_write       = wr;
        req_address     = addr;
        req_byte_enable = be;
        req_data        = data;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock); #1;
            req_valid = 1'b0;
            req_write = 1'b0;
        end
    endtask

    task automatic reset_and_clear();
        @(negedge clock); #1;
        reset = 1'b1; req_valid = 1'b0;
        idle(2);
        @(negedge clock); #1;
        reset = 1'b0;
        idle(MEM - 1);
        check("ready_low_before_clear_done", 32'(req_ready), 32'h0);
        idle(1);
        check("ready_high_after_clear", 32'(req_ready), 32'h1);
    endtask

    int unsigned base;

    initial begin
        reset_and_clear();

        // Every word reads zero after the clear sweep.
        base = resp_count;
        for (int i = 0; i < int'(MEM); i++) issue(1'b0, 32'(4 * i), 4'h0, 32'h0);
        idle(RL + 1);
        check("clear_load_count", resp_count - base, 32'd16);
        check("clear_load_data", last_data, 32'h0);

        // Full-word store then immediate load.
        issue(1'b1, 32'h8, 4'hF, 32'hDEADBEEF);
        issue(1'b0, 32'h8, 4'h0, 32'h0);
        idle(RL + 1);
        check("full_store_load", last_data, 32'hDEADBEEF);
        check("full_store_errs", {30'h0, last_inv, last_mis}, 32'h0);

        // Lane-masked store over all-ones.
        issue(1'b1, 32'h4, 4'hF, 32'hFFFFFFFF);
        issue(1'b1, 32'h4, 4'b0101, 32'h11223344);
        issue(1'b0, 32'h4, 4'h0, 32'h0);
        idle(RL + 1);
        check("lane_store_load", last_data, 32'hFF22FF44);

        // Misaligned load.
        issue(1'b0, 32'h6, 4'h0, 32'h0);
        idle(RL + 1);
        check("misaligned_flag", {30'h0, last_inv, last_mis}, 32'h1);
        check("misaligned_data", last_data, 32'h0);

        // Out-of-range stores, including one that would alias index 0 if truncated.
        issue(1'b1, 32'(4 * MEM), 4'hF, 32'h12345678);
        idle(RL + 1);
        check("invalid_store_flag", {30'h0, last_inv, last_mis}, 32'h2);
        check("invalid_store_write", 32'(last_write), 32'h1);
        issue(1'b1, 32'h80000000, 4'hF, 32'hCAFEF00D);
        issue(1'b0, 32'h0, 4'h0, 32'h0);
        idle(RL + 1);
        check("index0_unchanged", last_data, 32'h0);

        // No-op store still responds.
        base = resp_count;
        issue(1'b1, 32'h8, 4'h0, 32'h55555555);
        issue(1'b0, 32'h8, 4'h0, 32'h0);
        idle(RL + 1);
        check("noop_store_count", resp_count - base, 32'd2);
        check("noop_store_data", last_data, 32'hDEADBEEF);

        // Back-to-back alternating store/load on 8 addresses.
        base = resp_count;
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, 32'(4 * (i + 8)), 4'hF, 32'hA5A50000 + 32'(i));
            issue(1'b0, 32'(4 * (i + 8)), 4'h0, 32'h0);
        end
        idle(RL + 1);
        check("b2b_count", resp_count - base, 32'd16);
        check("b2b_last_data", last_data, 32'hA5A50007);

        // Reset with two loads in flight.
        issue(1'b0, 32'h8, 4'h0, 32'h0);
        issue(1'b0, 32'h4, 4'h0, 32'h0);
        base = resp_count;
        reset_and_clear();
        check("no_resp_after_reset", resp_count - base, 32'd0);
        issue(1'b0, 32'h8, 4'h0, 32'h0);
        issue(1'b0, 32'h28, 4'h0, 32'h0);
        idle(RL);
        check("recleared_word_8", last_data, 32'h0);
        idle(1);
        check("recleared_word_28", last_data, 32'h0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_memory.md
# data_memory

Parametrised word-organised data memory for the MIPS datapath, replacing the single-shot start-strobe memory. Accepts one read or write request per clock over a valid/ready handshake, supports byte-lane write enables and a configurable read pipeline depth, and clears itself to zero after reset. Every request produces exactly one in-order response carrying data and error flags, so the load/store stage can track outstanding accesses.

## Interface
- MEMORY_SIZE, 1024: depth in words; need not be a power of two.
- WORD_SIZE, 32: word width in bits; must be a multiple of 8.
- ADDRESS_WIDTH, 32: byte-address width.
- READ_LATENCY, 1: edges from request acceptance to response; legal range 1..4.
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; a request is accepted on an edge where req_valid && req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_address  in  ADDRESS_WIDTH  byte address.
- req_byte_enable  in  WORD_SIZE/8  lane strobes for stores; ignored for loads.
- req_data  in  WORD_SIZE  store data.
- resp_valid  out  1  one-cycle response pulse.
- resp_write  out  1  echo of req_write for this response.
- resp_data  out  WORD_SIZE  load data; 0 for stores and errored loads.
- err_invalid_address  out  1  word index >= MEMORY_SIZE; qualified by resp_valid.
- err_misaligned  out  1  address not word-aligned; qualified by resp_valid.

## Operation
- Word index = req_address >> log2(WORD_SIZE/8); misaligned = any low byte-offset bit set. Index computed at full ADDRESS_WIDTH, no truncation before range check.
- States: CLEAR, READY. Reset forces CLEAR with clear_index = 0. In CLEAR, one word per cycle is written to 0; after writing index MEMORY_SIZE-1, transition to READY. req_ready = (state == READY) && !reset.
- Store accepted without error: lanes with byte_enable=1 updated at the accept edge; other lanes untouched. byte_enable = 0 is a legal no-op store and still responds.
- Either error flag set: memory not modified; resp_data = 0; both flags reported independently (both may be 1).
- Load returns the word as of the accept edge; a store accepted on edge k is visible to a load accepted on edge k+1.
- Responses leave in acceptance order; no backpressure on the response side (consumer must always accept).
- Reset mid-operation: all in-flight responses discarded (no resp_valid after reset edge), memory re-cleared from index 0.

## Timing
- Reset values: req_ready 0, resp_valid 0, resp_write 0, resp_data 0, err_invalid_address 0, err_misaligned 0.
- Clear duration: req_ready rises MEMORY_SIZE edges after the edge on which reset is sampled low.
- Throughput: one request per cycle in READY, sustained.
- Latency: request accepted on edge k -> resp_valid high for exactly the cycle after edge k+READ_LATENCY-1... i.e. asserted by edge k+READ_LATENCY, deasserted by k+READ_LATENCY+1 unless another response follows. Stores use the same latency as loads.
- resp_* outputs registered; resp_data/flags hold 0 when resp_valid is 0.

## Structure
- Package data_memory_pkg: state enum (CLEAR, READY), byte-offset width function, READ_LATENCY legality check constants.
- Sub-module data_memory_response_pipe: READ_LATENCY-deep shift register of {valid, write, data, two error flags}, synchronous clear on reset. Stage 1 loads from the array read; later stages plain registers.
- Top holds array, clear FSM/counter, address decode and lane-masked write.

## Test plan
- Reset release, MEMORY_SIZE=16: req_ready 0 for 16 cycles then 1; load of every index returns 0x00000000.
- Store 0xDEADBEEF to address 0x8, enables 4'b1111, then load 0x8 next cycle -> resp_data 0xDEADBEEF with READ_LATENCY=3 spacing, both errors 0.
- Store 0x11223344 enables 4'b0101 over 0xFFFFFFFF at 0x4 -> load returns 0xFF22FF44.
- Load 0x6 -> err_misaligned 1, resp_data 0; store to byte address 4*MEMORY_SIZE -> err_invalid_address 1, subsequent load of index 0 unchanged.
- Back-to-back alternating store/load on 8 addresses, one per cycle -> 16 responses, in order, each exactly READ_LATENCY edges after acceptance.
- Assert reset with 2 loads in flight -> no resp_valid afterwards, req_ready low for MEMORY_SIZE cycles, prior stored data reads back 0.
